dff_input_debouncer: RTL and testbench

//   Input conditioner placed directly upstream of the d_flip_flop tile logic.

---
 rtl/dff_input_debouncer.sv | 147 ++++++++++++++
 tb/tb_dff_input_debouncer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dff_input_debouncer.sv
// Input conditioner for the d_flip_flop tile: it synchronises one raw pin, debounces it,
// and produces a clean level, edge strobes and a rising-edge counter.
module dff_input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] edge_count
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_dout;
  logic                   w_dout_nxt;
  logic                   r_rise;
  logic                   w_rise_nxt;
  logic                   r_fall;
  logic                   w_fall_nxt;
  logic [7:0]             r_edge_count;
  logic [7:0]             w_edge_count_nxt;

  // The synchroniser keeps running while ena=0 so that the pin is already
  // settled into clk by the time the FSM resumes.
  // NOTE: sequential state uses <= only, so every flop samples pre-edge values
  // and the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_LOW;
      r_cnt        <= '0;
      r_dout       <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_edge_count <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
      r_edge_count <= w_edge_count_nxt;
    end
  end

  // NOTE: every signal gets a hold/zero default before the case, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_dout_nxt       = r_dout;
    w_rise_nxt       = 1'b0;
    w_fall_nxt       = 1'b0;
    w_edge_count_nxt = r_edge_count;

    if (ena) begin
      unique case (r_state)
        ST_LOW: begin
          if (w_s) begin
            w_state_nxt = ST_WAIT_HIGH;
            w_cnt_nxt   = '0;
          end
        end

        ST_WAIT_HIGH: begin
          if (!w_s) begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TERMINAL) begin
            w_state_nxt      = ST_HIGH;
            w_cnt_nxt        = '0;
            w_dout_nxt       = 1'b1;
            w_rise_nxt       = 1'b1;
            w_edge_count_nxt = r_edge_count + 8'd1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        ST_HIGH: begin
          if (!w_s) begin
            w_state_nxt = ST_WAIT_LOW;
            w_cnt_nxt   = '0;
          end
        end

        ST_WAIT_LOW: begin
          if (w_s) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TERMINAL) begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
            w_dout_nxt  = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        default: begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Strobes are masked by ena as well, so a pulse registered on the last enabled
  // edge cannot be seen while the tile is disabled.
  assign dout       = r_dout;
  assign rise       = r_rise & ena;
  assign fall       = r_fall & ena;
  assign busy       = (r_state == ST_WAIT_HIGH) || (r_state == ST_WAIT_LOW);
  assign edge_count = r_edge_count;

endmodule

// File: tb/tb_dff_input_debouncer.sv
// Directed bench for dff_input_debouncer with SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
// The accepting edge lands 6 edges after the first edge that samples a new din level.
module tb_dff_input_debouncer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       din;
  logic       dout;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] edge_count;

  int n_tests;
  int n_fail;

  dff_input_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .din       (din),
    .dout      (dout),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .edge_count(edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n edges and sample 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_dout, input logic e_rise,
                           input logic e_fall, input logic e_busy, input logic [7:0] e_cnt);
    check({tag, ".dout"}, {7'd0, dout}, {7'd0, e_dout});
    check({tag, ".rise"}, {7'd0, rise}, {7'd0, e_rise});
    check({tag, ".fall"}, {7'd0, fall}, {7'd0, e_fall});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
    check({tag, ".cnt"},  edge_count,   e_cnt);
  endtask

  // A clean press/release pair: 7 edges high then 7 low reaches acceptance each way.
  task automatic press_release();
    din = 1'b1;
    tick(7);
    din = 1'b0;
    tick(7);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    ena = 1'b1;
    din = 1'b0;

    // 1. Reset with din toggling
    din = 1'b1;
    tick(1);
    din = 1'b0;
    tick(1);
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    tick(4);
    check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 2. Clean rise: sample j is taken after edge E+j
    din = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      check_all($sformatf("rise_e%0d", j), (j >= 6), (j == 6), 1'b0,
                (j >= 2 && j <= 5), (j >= 6) ? 8'd1 : 8'd0);
    end

    // 4. Clean fall from HIGH
    din = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      check_all($sformatf("fall_e%0d", j), (j < 6), 1'b0, (j == 6),
                (j >= 2 && j <= 5), 8'd1);
    end

    // 3. Glitch: three cycles high, then low again
    din = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      if (j == 2) din = 1'b0;
      check_all($sformatf("glitch_e%0d", j), 1'b0, 1'b0, 1'b0,
                (j >= 2 && j <= 4), 8'd1);
    end

    // 5. Wrap: 254 more pairs bring the count to 255, then the 256th rise wraps
    for (int k = 0; k < 254; k++) press_release();
    check("wrap_255", edge_count, 8'd255);
    din = 1'b1;
    tick(6);
    check_all("wrap_pre", 1'b0, 1'b0, 1'b0, 1'b1, 8'd255);
    tick(1);
    check_all("wrap_256", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    din = 1'b0;
    tick(8);
    check_all("wrap_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 6a. Reset during WAIT_HIGH
    din = 1'b1;
    tick(4);
    check_all("rstw_wait", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    rst = 1'b1;
    tick(1);
    check_all("rstw_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    tick(6);
    check_all("rstw_pre", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    tick(1);
    check_all("rstw_acc", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    din = 1'b0;
    tick(8);
    check_all("rstw_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // 6b. ena=0 for 5 edges during WAIT_HIGH delays acceptance from E+6 to E+11
    din = 1'b1;
    tick(4);
    check_all("ena_wait", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    ena = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick(1);
      check_all($sformatf("ena_off%0d", j), 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    end
    ena = 1'b1;
    tick(1);
    check_all("ena_e9", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    tick(1);
    check_all("ena_e10", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    tick(1);
    check_all("ena_e11", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    tick(1);
    check_all("ena_e12", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
